// File: rtl/store_buffer_fwd.sv
// In-order store queue: dispatch allocation, sqid-indexed writeback, multi-port commit,
// in-order drain to the dcache and store-to-load forwarding (byte merge when STORE_BUFFER_BYTE_FWD_EN).

module store_buffer_fwd_entry #(
  parameter int ROBID_W = 7,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int NCOMMIT = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       alloc,
  input  logic [ROBID_W-1:0]         alloc_robid,
  input  logic                       wb_we,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic [DATA_W/8-1:0]        wb_mask,
  input  logic                       wb_mmio,
  input  logic [NCOMMIT-1:0]         commit_valid,
  input  logic [NCOMMIT*ROBID_W-1:0] commit_robid,
  input  logic                       kill,
  input  logic                       free,
  output logic                       valid,
  output logic                       wb_done,
  output logic                       committed,
  output logic                       mmio,
  output logic [ADDR_W-1:0]          addr,
  output logic [DATA_W-1:0]          data,
  output logic [DATA_W/8-1:0]        mask
);
  logic [ROBID_W-1:0] robid;
  logic               commit_hit;

  always_comb begin
    commit_hit = 1'b0;
    for (int k = 0; k < NCOMMIT; k++)
      if (commit_valid[k] && commit_robid[k*ROBID_W +: ROBID_W] == robid) commit_hit = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid     <= 1'b0;
      wb_done   <= 1'b0;
      committed <= 1'b0;
      mmio      <= 1'b0;
      robid     <= '0;
      addr      <= '0;
      data      <= '0;
      mask      <= '0;
    end else if (alloc) begin
      valid     <= 1'b1;
      wb_done   <= 1'b0;
      committed <= 1'b0;
      mmio      <= 1'b0;
      robid     <= alloc_robid;
    end else if (free || kill) begin
      valid     <= 1'b0;
      wb_done   <= 1'b0;
      committed <= 1'b0;
      mmio      <= 1'b0;
    end else if (valid) begin
      if (wb_we) begin
        wb_done <= 1'b1;
        mmio    <= wb_mmio;
        addr    <= wb_addr;
        data    <= wb_data;
        mask    <= wb_mask;
      end
      if (commit_hit) committed <= 1'b1;
    end
  end
endmodule

`ifdef STORE_BUFFER_BYTE_FWD_EN
// One forwarding byte lane: walks entries oldest to youngest so the youngest hit wins.
module store_buffer_fwd_lane #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]         sel,
  input  logic [DEPTH-1:0][7:0]    lane_bytes,
  input  logic [$clog2(DEPTH)-1:0] start,
  output logic                     hit,
  output logic [7:0]               data
);
  localparam int IDX_W = $clog2(DEPTH);

  always_comb begin
    logic [IDX_W-1:0] idx;
    idx  = start;
    hit  = 1'b0;
    data = 8'h00;
    for (int k = 0; k < DEPTH; k++) begin
      idx = start + IDX_W'(k);
      if (sel[idx]) begin
        hit  = 1'b1;
        data = lane_bytes[idx];
      end
    end
  end
endmodule
`endif

module store_buffer_fwd #(
  parameter int DEPTH   = 16,
  parameter int ROBID_W = 7,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int NCOMMIT = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [ROBID_W-1:0]         enq_robid,
  output logic [$clog2(DEPTH):0]     enq_sqid,
  input  logic                       wb_valid,
  input  logic [$clog2(DEPTH):0]     wb_sqid,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic [DATA_W/8-1:0]        wb_mask,
  input  logic                       wb_mmio,
  input  logic [NCOMMIT-1:0]         commit_valid,
  input  logic [NCOMMIT*ROBID_W-1:0] commit_robid,
  input  logic                       flush_valid,
  input  logic [$clog2(DEPTH):0]     flush_sqid,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data,
  output logic [DATA_W/8-1:0]        mem_mask,
  input  logic                       fwd_valid,
  input  logic [$clog2(DEPTH):0]     fwd_sqid,
  input  logic [ADDR_W-1:0]          fwd_addr,
  input  logic [DATA_W/8-1:0]        fwd_mask,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [DATA_W/8-1:0]        fwd_hit_mask,
  output logic                       fwd_stall,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  logic [PTR_W-1:0] enq_ptr, deq_ptr, count_q, enq_nxt, deq_nxt;
  logic [PTR_W-1:0] flush_span, fwd_span;
  logic [IDX_W-1:0] enq_idx, deq_idx, flush_idx;
  logic             full, enq_fire, head_elig, deq_fire;

  logic [DEPTH-1:0]             e_valid, e_wb, e_cm, e_mmio;
  logic [DEPTH-1:0][ADDR_W-1:0] e_addr;
  logic [DEPTH-1:0][DATA_W-1:0] e_data;
  logic [DEPTH-1:0][BYTES-1:0]  e_mask;
  logic [DEPTH-1:0]             kill, in_rng, match;

  assign enq_idx   = enq_ptr[IDX_W-1:0];
  assign deq_idx   = deq_ptr[IDX_W-1:0];
  assign flush_idx = flush_sqid[IDX_W-1:0];
  assign full      = (enq_idx == deq_idx) && (enq_ptr[IDX_W] != deq_ptr[IDX_W]);
  assign enq_ready = ~full & ~flush_valid;
  assign enq_fire  = enq_valid & enq_ready;
  assign enq_sqid  = enq_ptr;
  assign count     = count_q;

  // Distances from the window start; an entry is inside when its offset is below the span.
  assign flush_span = enq_ptr - flush_sqid;
  assign fwd_span   = fwd_sqid - deq_ptr;

  assign head_elig = e_valid[deq_idx] & e_wb[deq_idx] & e_cm[deq_idx];
  assign mem_valid = head_elig & ~e_mmio[deq_idx];
  assign deq_fire  = head_elig & (e_mmio[deq_idx] | mem_ready);
  assign mem_addr  = mem_valid ? e_addr[deq_idx] : '0;
  assign mem_data  = mem_valid ? e_data[deq_idx] : '0;
  assign mem_mask  = mem_valid ? e_mask[deq_idx] : '0;

  assign deq_nxt = deq_ptr + PTR_W'(deq_fire);
  assign enq_nxt = flush_valid ? flush_sqid : enq_ptr + PTR_W'(enq_fire);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      count_q <= '0;
    end else begin
      enq_ptr <= enq_nxt;
      deq_ptr <= deq_nxt;
      count_q <= enq_nxt - deq_nxt;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [IDX_W-1:0] flush_off, fwd_off;
    assign flush_off = IDX_W'(i) - flush_idx;
    assign fwd_off   = IDX_W'(i) - deq_idx;
    assign kill[i]   = flush_valid & e_valid[i] & ~e_cm[i] & ({1'b0, flush_off} < flush_span);
    assign in_rng[i] = e_valid[i] & ({1'b0, fwd_off} < fwd_span);
    assign match[i]  = e_wb[i] & (e_addr[i][ADDR_W-1:OFF_W] == fwd_addr[ADDR_W-1:OFF_W]);

    store_buffer_fwd_entry #(
      .ROBID_W(ROBID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NCOMMIT(NCOMMIT)
    ) u_ent (
      .clock        (clock),
      .reset_n      (reset_n),
      .alloc        (enq_fire && enq_idx == IDX_W'(i)),
      .alloc_robid  (enq_robid),
      .wb_we        (wb_valid && wb_sqid[IDX_W-1:0] == IDX_W'(i)),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .wb_mask      (wb_mask),
      .wb_mmio      (wb_mmio),
      .commit_valid (commit_valid),
      .commit_robid (commit_robid),
      .kill         (kill[i]),
      .free         (deq_fire && deq_idx == IDX_W'(i)),
      .valid        (e_valid[i]),
      .wb_done      (e_wb[i]),
      .committed    (e_cm[i]),
      .mmio         (e_mmio[i]),
      .addr         (e_addr[i]),
      .data         (e_data[i]),
      .mask         (e_mask[i])
    );
  end

  logic unused_bits;

`ifdef STORE_BUFFER_BYTE_FWD_EN
  for (genvar b = 0; b < BYTES; b++) begin : g_lane
    logic [DEPTH-1:0]      sel;
    logic [DEPTH-1:0][7:0] col;
    logic                  hit;
    logic [7:0]            byte_d;
    for (genvar i = 0; i < DEPTH; i++) begin : g_col
      assign sel[i] = in_rng[i] & match[i] & e_mask[i][b];
      assign col[i] = e_data[i][8*b +: 8];
    end
    store_buffer_fwd_lane #(.DEPTH(DEPTH)) u_lane (
      .sel(sel), .lane_bytes(col), .start(deq_idx), .hit(hit), .data(byte_d)
    );
    assign fwd_hit_mask[b]    = fwd_valid & fwd_mask[b] & hit;
    assign fwd_data[8*b +: 8] = fwd_hit_mask[b] ? byte_d : 8'h00;
  end
  assign fwd_stall   = fwd_valid & |(in_rng & (~e_wb | (match & e_mmio)));
  assign unused_bits = ^{wb_sqid[IDX_W], fwd_addr[OFF_W-1:0]};
`else
  // No merge: any older overlapping or unresolved store forces the load to replay.
  assign fwd_data     = '0;
  assign fwd_hit_mask = '0;
  assign fwd_stall    = fwd_valid & |(in_rng & (match | ~e_wb));
  assign unused_bits  = ^{wb_sqid[IDX_W], fwd_addr[OFF_W-1:0], fwd_mask};
`endif
endmodule

// File: tb/tb_store_buffer_fwd.sv
// Directed bench for store_buffer_fwd: fill/wrap, dual commit, MMIO, flush, forwarding merge
// and stall; drained stores are checked against a scoreboard queue.

module tb_store_buffer_fwd;
  localparam int PTR_W = 5;

  logic        clock, reset_n;
  logic        enq_valid, enq_ready;
  logic [6:0]  enq_robid;
  logic [4:0]  enq_sqid;
  logic        wb_valid;
  logic [4:0]  wb_sqid;
  logic [63:0] wb_addr, wb_data;
  logic [7:0]  wb_mask;
  logic        wb_mmio;
  logic [1:0]  commit_valid;
  logic [13:0] commit_robid;
  logic        flush_valid;
  logic [4:0]  flush_sqid;
  logic        mem_valid, mem_ready;
  logic [63:0] mem_addr, mem_data;
  logic [7:0]  mem_mask;
  logic        fwd_valid;
  logic [4:0]  fwd_sqid;
  logic [63:0] fwd_addr, fwd_data;
  logic [7:0]  fwd_mask, fwd_hit_mask;
  logic        fwd_stall;
  logic [4:0]  count;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } mem_t;

  mem_t sb[$];
  int checks = 0;
  int errors = 0;

  store_buffer_fwd dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_robid(enq_robid), .enq_sqid(enq_sqid),
    .wb_valid(wb_valid), .wb_sqid(wb_sqid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_mask(wb_mask), .wb_mmio(wb_mmio),
    .commit_valid(commit_valid), .commit_robid(commit_robid),
    .flush_valid(flush_valid), .flush_sqid(flush_sqid),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_mask(mem_mask),
    .fwd_valid(fwd_valid), .fwd_sqid(fwd_sqid), .fwd_addr(fwd_addr), .fwd_mask(fwd_mask),
    .fwd_data(fwd_data), .fwd_hit_mask(fwd_hit_mask), .fwd_stall(fwd_stall),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fwd_chk(input string tag, input logic [63:0] d, input logic [7:0] h, input logic s);
    #1;
    chk({tag, "_data"}, fwd_data, d);
    chk({tag, "_hit"}, {56'h0, fwd_hit_mask}, {56'h0, h});
    chk({tag, "_stall"}, {63'h0, fwd_stall}, {63'h0, s});
  endtask

  // Drained stores are compared in order at acceptance; any mem_valid with nothing expected is an error.
  always @(negedge clock) begin : mon
    mem_t e;
    if (reset_n && mem_valid) begin
      if (sb.size() == 0) chk("mem_unexpected", 64'd1, 64'd0);
      else if (mem_ready) begin
        e = sb.pop_front();
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_data", mem_data, e.data);
        chk("mem_mask", {56'h0, mem_mask}, {56'h0, e.mask});
      end
    end
  end

  initial begin
    reset_n = 0; enq_valid = 0; enq_robid = 0; wb_valid = 0; wb_sqid = 0; wb_addr = 0;
    wb_data = 0; wb_mask = 0; wb_mmio = 0; commit_valid = 0; commit_robid = 0;
    flush_valid = 0; flush_sqid = 0; mem_ready = 0;
    fwd_valid = 1; fwd_sqid = 0; fwd_addr = 0; fwd_mask = 8'hFF;

    // reset state
    #12;
    chk("rst_enq_ready", {63'h0, enq_ready}, 64'd1);
    chk("rst_enq_sqid", {59'h0, enq_sqid}, 64'd0);
    chk("rst_count", {59'h0, count}, 64'd0);
    chk("rst_mem_valid", {63'h0, mem_valid}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    fwd_chk("rst_fwd", 64'd0, 8'h00, 1'b0);
    @(negedge clock); reset_n = 1; fwd_valid = 0;
    tick();

    // fill: sqids 0..15, robid = sqid + 5
    for (int i = 0; i < 16; i++) begin
      chk("fill_sqid", {59'h0, enq_sqid}, 64'(i));
      chk("fill_ready", {63'h0, enq_ready}, 64'd1);
      enq_valid = 1; enq_robid = 7'(i + 5);
      tick();
    end
    enq_valid = 0;
    #1;
    chk("full_ready", {63'h0, enq_ready}, 64'd0);
    chk("full_count", {59'h0, count}, 64'd16);

    // writeback sq0 and sq1; sq1's write is in flight while the load looks
    wb_valid = 1; wb_sqid = 0; wb_addr = 64'h100; wb_data = 64'h1111_1111; wb_mask = 8'h0F; wb_mmio = 0;
    tick();
    wb_sqid = 1; wb_data = 64'h2222; wb_mask = 8'h03;
    fwd_valid = 1; fwd_sqid = 2; fwd_addr = 64'h100; fwd_mask = 8'hFF;
    #1 chk("same_cycle_wb_stall", {63'h0, fwd_stall}, 64'd1);
    tick();
    wb_valid = 0;
`ifdef STORE_BUFFER_BYTE_FWD_EN
    fwd_chk("merge", 64'h0000_0000_1111_2222, 8'h0F, 1'b0);
    fwd_mask = 8'h0C;
    fwd_chk("merge_part", 64'h0000_0000_1111_0000, 8'h0C, 1'b0);
    fwd_mask = 8'hFF; fwd_sqid = 1;
    fwd_chk("older_only", 64'h0000_0000_1111_1111, 8'h0F, 1'b0);
`else
    fwd_chk("merge", 64'd0, 8'h00, 1'b1);
    fwd_mask = 8'h0C;
    fwd_chk("merge_part", 64'd0, 8'h00, 1'b1);
    fwd_mask = 8'hFF; fwd_sqid = 1;
    fwd_chk("older_only", 64'd0, 8'h00, 1'b1);
`endif
    fwd_sqid = 3; fwd_addr = 64'h900;
    #1 chk("pending_wb_stall", {63'h0, fwd_stall}, 64'd1);
    fwd_valid = 0;
    fwd_chk("fwd_idle", 64'd0, 8'h00, 1'b0);

    // dual commit of robids 5 and 6
    mem_ready = 1;
    commit_valid = 2'b11; commit_robid = {7'd6, 7'd5};
    sb.push_back('{addr: 64'h100, data: 64'h1111_1111, mask: 8'h0F});
    sb.push_back('{addr: 64'h100, data: 64'h2222, mask: 8'h03});
    #1 chk("commit_cycle_mem_valid", {63'h0, mem_valid}, 64'd0);
    tick();
    commit_valid = 0;
    #1 chk("commit_next_mem_valid", {63'h0, mem_valid}, 64'd1);
    chk("still_full", {63'h0, enq_ready}, 64'd0);
    tick();
    chk("deq_ready", {63'h0, enq_ready}, 64'd1);
    chk("wrap_sqid", {59'h0, enq_sqid}, 64'd16);
    chk("count_15", {59'h0, count}, 64'd15);
    tick();
    chk("count_14", {59'h0, count}, 64'd14);
    chk("drained_mem_valid", {63'h0, mem_valid}, 64'd0);

    // MMIO head (sq2, robid 7): writeback and commit in one cycle, retires without mem_valid
    wb_valid = 1; wb_sqid = 2; wb_addr = 64'h200; wb_data = 64'hDEAD; wb_mask = 8'hFF; wb_mmio = 1;
    commit_valid = 2'b01; commit_robid = {7'd0, 7'd7};
    tick();
    wb_valid = 0; wb_mmio = 0; commit_valid = 0;
    #1 chk("mmio_mem_valid", {63'h0, mem_valid}, 64'd0);
    chk("mmio_count_pre", {59'h0, count}, 64'd14);
    tick();
    chk("mmio_count_post", {59'h0, count}, 64'd13);

    // flush with a committed head (sq3) held by mem_ready=0
    mem_ready = 0;
    wb_valid = 1; wb_sqid = 3; wb_addr = 64'h300; wb_data = 64'h0123_4567_89AB_CDEF; wb_mask = 8'hFF;
    commit_valid = 2'b01; commit_robid = {7'd0, 7'd8};
    sb.push_back('{addr: 64'h300, data: 64'h0123_4567_89AB_CDEF, mask: 8'hFF});
    tick();
    wb_valid = 0; commit_valid = 0;
    #1 chk("hold_valid", {63'h0, mem_valid}, 64'd1);
    tick();
    chk("hold_addr", mem_addr, 64'h300);
    flush_valid = 1; flush_sqid = 4; enq_valid = 1; enq_robid = 7'd99;
    #1 chk("flush_enq_ready", {63'h0, enq_ready}, 64'd0);
    tick();
    flush_valid = 0; enq_valid = 0;
    #1;
    chk("flush_sqid", {59'h0, enq_sqid}, 64'd4);
    chk("flush_count", {59'h0, count}, 64'd1);
    chk("flush_ready", {63'h0, enq_ready}, 64'd1);
    chk("flush_keeps_committed", {63'h0, mem_valid}, 64'd1);
    fwd_valid = 1; fwd_sqid = 8; fwd_addr = 64'h500; fwd_mask = 8'hFF;
    #1 chk("flushed_no_stall", {63'h0, fwd_stall}, 64'd0);
    fwd_addr = 64'h300;
`ifdef STORE_BUFFER_BYTE_FWD_EN
    fwd_chk("fwd_sq3", 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
`else
    fwd_chk("fwd_sq3", 64'd0, 8'h00, 1'b1);
`endif
    fwd_valid = 0;

    // asynchronous reset while a store is being offered
    #2 reset_n = 0;
    #1;
    chk("async_rst_mem_valid", {63'h0, mem_valid}, 64'd0);
    chk("async_rst_count", {59'h0, count}, 64'd0);
    sb.delete();
    @(negedge clock); reset_n = 1;
    tick();

    // advance deq_ptr to 14 through the cache path
    for (int i = 0; i < 14; i++) begin
      enq_valid = 1; enq_robid = 7'(20 + i);
      tick();
    end
    enq_valid = 0;
    for (int i = 0; i < 14; i++) begin
      wb_valid = 1; wb_sqid = 5'(i); wb_addr = 64'h1000 + 64'(8 * i);
      wb_data = 64'hA5A5_0000_0000_0000 | 64'(i); wb_mask = 8'hFF;
      tick();
    end
    wb_valid = 0;
    mem_ready = 1;
    for (int j = 0; j < 7; j++) begin
      commit_valid = 2'b11; commit_robid = {7'(21 + 2 * j), 7'(20 + 2 * j)};
      for (int k = 0; k < 2; k++)
        sb.push_back('{addr: 64'h1000 + 64'(8 * (2 * j + k)),
                       data: 64'hA5A5_0000_0000_0000 | 64'(2 * j + k), mask: 8'hFF});
      tick();
    end
    commit_valid = 0;
    for (int c = 0; c < 100 && count != 0; c++) tick();
    chk("drain_count", {59'h0, count}, 64'd0);
    chk("drain_sqid", {59'h0, enq_sqid}, 64'd14);
    mem_ready = 0;

    // sqids 14, 15, 16 (wrap flag set, index 0)
    for (int i = 0; i < 3; i++) begin
      chk("wrap_enq_sqid", {59'h0, enq_sqid}, 64'(14 + i));
      enq_valid = 1; enq_robid = 7'(40 + i);
      tick();
    end
    enq_valid = 0;
    wb_valid = 1; wb_sqid = 14; wb_addr = 64'h2000; wb_data = 64'h1111_2222_3333_4444; wb_mask = 8'hFF;
    tick();
    wb_sqid = 16; wb_data = 64'h5555_6666_7777_8888; wb_mask = 8'hF0;
    tick();
    wb_valid = 0;
    fwd_valid = 1; fwd_sqid = 17; fwd_addr = 64'h2000; fwd_mask = 8'hFF;
`ifdef STORE_BUFFER_BYTE_FWD_EN
    fwd_chk("wrap_stall", 64'h5555_6666_3333_4444, 8'hFF, 1'b1);
    fwd_sqid = 15;
    fwd_chk("wrap_one", 64'h1111_2222_3333_4444, 8'hFF, 1'b0);
`else
    fwd_chk("wrap_stall", 64'd0, 8'h00, 1'b1);
    fwd_sqid = 15;
    fwd_chk("wrap_one", 64'd0, 8'h00, 1'b1);
`endif
    fwd_valid = 0;
    wb_valid = 1; wb_sqid = 15; wb_addr = 64'h2800; wb_data = 64'h9999; wb_mask = 8'hFF;
    tick();
    wb_valid = 0;
    fwd_valid = 1; fwd_sqid = 17; fwd_addr = 64'h2000;
`ifdef STORE_BUFFER_BYTE_FWD_EN
    fwd_chk("wrap_merge", 64'h5555_6666_3333_4444, 8'hFF, 1'b0);
`else
    fwd_chk("wrap_merge", 64'd0, 8'h00, 1'b1);
`endif
    fwd_addr = 64'h4000;
    fwd_chk("wrap_nomatch", 64'd0, 8'h00, 1'b0);
    fwd_valid = 0;
    fwd_chk("wrap_idle", 64'd0, 8'h00, 1'b0);

    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
